// File: rtl/vec_field_packer.sv
// rtl/vec_field_packer.sv - packs six 5-bit fields plus a tail into a word and streams it out as four bytes
module vec_field_packer #(
  parameter logic [1:0] TAIL = 2'b11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       busy
);

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  fcnt;
  logic [1:0]  bcnt;
  logic [29:0] acc;
  logic [31:0] word;
  logic        in_fire;
  logic        out_fire;
  logic        last_field;
  logic        last_byte;
  logic [7:0]  byte_sel;

  assign in_fire    = in_valid & in_ready;
  assign out_fire   = out_valid & out_ready;
  assign last_field = (fcnt == 3'd5);
  assign last_byte  = (bcnt == 2'd3);

  // State register; reset abandons any word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: clear wins over both handshakes.
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = COLLECT;
    end else begin
      case (state)
        COLLECT: if (in_fire && last_field) state_nxt = EMIT;
        EMIT:    if (out_fire && last_byte) state_nxt = COLLECT;
        default: state_nxt = COLLECT;
      endcase
    end
  end

  // Byte select, most-significant byte first.
  always_comb begin
    byte_sel = 8'd0;
    case (bcnt)
      2'd0: byte_sel = word[31:24];
      2'd1: byte_sel = word[23:16];
      2'd2: byte_sel = word[15:8];
      2'd3: byte_sel = word[7:0];
      default: byte_sel = 8'd0;
    endcase
  end

  // Outputs are pure decodes of registered state, so the two streams never couple combinationally.
  always_comb begin
    in_ready  = (state == COLLECT);
    out_valid = (state == EMIT);
    out_data  = 8'd0;
    out_last  = 1'b0;
    if (state == EMIT) begin
      out_data = byte_sel;
      out_last = last_byte;
    end
    busy = (state != COLLECT) || (fcnt != 3'd0);
  end

  // Field accumulator; the sixth field snapshots the full word with the tail appended.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt <= 3'd0;
      acc  <= 30'd0;
      word <= 32'd0;
    end else if (clear) begin
      fcnt <= 3'd0;
      acc  <= 30'd0;
    end else if (in_fire) begin
      acc <= {acc[24:0], in_data};
      if (last_field) begin
        word <= {acc[24:0], in_data, TAIL};
        fcnt <= 3'd0;
      end else begin
        fcnt <= fcnt + 3'd1;
      end
    end
  end

  // Byte counter: restarts when a new word is latched, advances on each accepted byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt <= 2'd0;
    end else if (clear) begin
      bcnt <= 2'd0;
    end else if (in_fire && last_field) begin
      bcnt <= 2'd0;
    end else if (out_fire) begin
      if (last_byte) begin
        bcnt <= 2'd0;
      end else begin
        bcnt <= bcnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_vec_field_packer.sv
// tb/tb_vec_field_packer.sv - scoreboard bench for vec_field_packer
module tb_vec_field_packer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic [4:0] in_data;
  logic       out_ready;
  logic       in_ready, out_valid, out_last, busy;
  logic [7:0] out_data;
  logic       in_ready_z, out_valid_z, out_last_z, busy_z;
  logic [7:0] out_data_z;

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;

  typedef struct packed {
    logic [7:0] b3;
    logic [7:0] b0;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  int   partial[$];

  always #5 clk = ~clk;

  vec_field_packer dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  vec_field_packer #(.TAIL(2'b00)) dut_z (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_z), .in_data(in_data),
    .out_valid(out_valid_z), .out_ready(out_ready), .out_data(out_data_z),
    .out_last(out_last_z), .busy(busy_z)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Reference: word = {f0..f5, tail}, cut into bytes most-significant first.
  function automatic void push_word();
    logic [29:0] f;
    logic [31:0] w3, w0, t3, t0;
    exp_t e;
    f = '0;
    foreach (partial[i]) f = (f << 5) | 30'(partial[i]);
    w3 = {f, 2'b11};
    w0 = {f, 2'b00};
    for (int k = 0; k < 4; k++) begin
      t3 = w3 >> (24 - 8 * k);
      t0 = w0 >> (24 - 8 * k);
      e.b3 = t3[7:0];
      e.b0 = t0[7:0];
      e.last = (k == 3);
      exp_q.push_back(e);
    end
  endfunction

  // Monitor: compare presented outputs with the model, then advance the model on handshakes.
  initial begin
    bit ev;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        partial.delete();
      end else begin
        ev = (exp_q.size() > 0);
        chk("out_valid", 32'(out_valid), 32'(ev));
        chk("in_ready", 32'(in_ready), 32'(!ev));
        chk("busy", 32'(busy), 32'(ev || partial.size() > 0));
        chk("out_valid_tail0", 32'(out_valid_z), 32'(ev));
        if (ev && out_valid) begin
          chk("out_data", 32'(out_data), 32'(exp_q[0].b3));
          chk("out_last", 32'(out_last), 32'(exp_q[0].last));
          chk("out_data_tail0", 32'(out_data_z), 32'(exp_q[0].b0));
        end
        if (clear) begin
          exp_q.delete();
          partial.delete();
        end else begin
          if (ev && out_ready) void'(exp_q.pop_front());
          if (!ev && in_valid) begin
            partial.push_back(int'(in_data));
            if (partial.size() == 6) begin
              push_word();
              partial.delete();
            end
          end
        end
      end
    end
  end

  // Consumer: always ready, random ready, or left to the directed tasks.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 1) out_ready = 1'b1;
      else if (rdy_mode == 2) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_field(input logic [4:0] v);
    int  n;
    bit  took;
    n = 0;
    took = 0;
    in_valid = 1'b1;
    in_data = v;
    while (!took && n < 2000) begin
      @(negedge clk);
      took = in_ready && !clear;
      step();
      n++;
    end
    in_valid = 1'b0;
    if (!took) timeout_fail("send_field");
  endtask

  task automatic send_word(input logic [4:0] f0, f1, f2, f3, f4, f5, input int gap);
    logic [4:0] f[6];
    f = '{f0, f1, f2, f3, f4, f5};
    for (int i = 0; i < 6; i++) begin
      send_field(f[i]);
      for (int g = 0; g < gap; g++) step();
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 5000) begin
      step();
      n++;
    end
    if (exp_q.size() > 0) timeout_fail("wait_idle");
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    in_valid = 1'b0;
    in_data = 5'd0;
    out_ready = 1'b0;
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", 32'(out_data), 32'd0);
    chk("reset_out_last", 32'(out_last), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    #11;
    rst_n = 1'b1;
    step();

    // Back-to-back word with the consumer always ready.
    rdy_mode = 1;
    send_word(5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 0);
    wait_idle();

    // Boundary values (the TAIL=0 instance is checked alongside).
    send_word(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0);
    wait_idle();
    send_word(5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 0);
    wait_idle();

    // Input gaps between fields.
    send_word(5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 1);
    wait_idle();

    // Backpressure on byte 2 while field 7 is already being offered.
    rdy_mode = 0;
    out_ready = 1'b0;
    send_word(5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 0);
    fork
      begin
        send_word(5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 0);
      end
      begin
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        repeat (5) step();
        out_ready = 1'b1;
      end
    join
    wait_idle();

    // Clear after three fields discards them.
    rdy_mode = 1;
    send_field(5'd9);
    send_field(5'd10);
    send_field(5'd11);
    clear = 1'b1;
    step();
    clear = 1'b0;
    send_word(5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 0);
    wait_idle();

    // Clear while byte 2 is being presented (and handshaking).
    rdy_mode = 0;
    out_ready = 1'b1;
    send_word(5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 0);
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (4) step();

    // Asynchronous reset while byte 1 is held.
    out_ready = 1'b0;
    send_word(5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    chk("async_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    step();
    rdy_mode = 1;
    send_word(5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 0);
    wait_idle();

    // Random stream with random gaps and random consumer stalls.
    rdy_mode = 2;
    for (int w = 0; w < 200; w++) begin
      for (int i = 0; i < 6; i++) begin
        send_field(5'($urandom_range(0, 31)));
        if ($urandom_range(0, 2) == 0) step();
      end
    end
    rdy_mode = 1;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vec_field_packer.md
# vec_field_packer

Upstream feeder for the six-field byte splitter. It accepts six 5-bit fields one at a time over a valid/ready stream and packs them MSB-first with a 2-bit tail into a 32-bit word. It then emits that word as four bytes, most-significant first, on a second valid/ready stream. The emitted bytes are in the same order as the splitter's w, x, y, z outputs. This lets a narrow serial source drive the packed-word datapath without a wide parallel bus.

## Interface

Parameters:
- TAIL, default 2'b11: constant appended as word bits [1:0].

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous abort; discards any partial word or pending bytes.
- in_valid  input  1  field present on in_data.
- in_ready  output  1  block can accept a field.
- in_data  input  5  field value.
- out_valid  output  1  byte present on out_data.
- out_ready  input  1  consumer accepts the byte.
- out_data  output  8  packed byte.
- out_last  output  1  high with the 4th byte of each word.
- busy  output  1  high whenever state is not COLLECT with field count 0.

## Operation

- State machine has two states, COLLECT and EMIT. It uses a 3-bit field counter fcnt (0..5), a 2-bit byte counter bcnt (0..3), and a 30-bit accumulator acc.
- COLLECT:
  - in_ready=1 and out_valid=0.
  - On in_valid&in_ready, acc <= {acc[24:0], in_data} and fcnt increments.
  - On the handshake at fcnt==5: latch word <= {acc[24:0], in_data, TAIL}, set fcnt <= 0 and bcnt <= 0, and move to EMIT.
- Field order:
  - The first accepted field lands in word[31:27] and the sixth in word[6:2].
  - The word equals the concatenation {f0,f1,f2,f3,f4,f5,TAIL}.
- EMIT:
  - in_ready=0 and out_valid=1.
  - out_data = word[31-8*bcnt -: 8]; out_last = (bcnt==3).
  - On out_valid&out_ready, bcnt increments. If bcnt==3, state returns to COLLECT.
- Holding rule: out_data and out_last stay stable while out_valid=1 and out_ready=0.
- Input blocking: a field offered during EMIT is not accepted. in_ready=0 there, and the source must hold it.
- clear:
  - Next cycle: state=COLLECT, fcnt=0, bcnt=0, acc=0, out_valid=0.
  - It overrides any same-cycle input or output handshake. A field or byte handshaking in the clear cycle is dropped, and it is not counted.
- Reset values: in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0, state=COLLECT, all counters 0, acc/word=0.
- Reset asserted mid-word or mid-emit immediately abandons all progress. No partial byte is ever emitted afterwards.
- Arithmetic: counters wrap only by explicit reset to 0. fcnt never exceeds 5 and bcnt never exceeds 3.

## Timing

- in_ready and out_valid are registered state decodes, not combinational on the opposite stream's handshake.
- Latency: out_valid rises in the cycle after the 6th field handshake.
- Throughput is fixed per word: 6 field cycles followed by 4 byte cycles, so the minimum word period is 10 cycles with no bubbles.
- After the last-byte handshake, in_ready is 1 in the following cycle.
- The block has no combinational path from in_valid to out_* or from out_ready to in_ready.
- With out_ready held low, the first byte is held indefinitely.
- With in_valid dropping between fields, COLLECT waits and keeps fcnt and acc.

## Test plan

- Back-to-back input: fields 1,2,3,4,5,6 with out_ready=1. Required response:
  - Bytes 0x08, 0x86, 0x42, 0x9B on consecutive cycles.
  - out_last only on 0x9B.
  - out_valid first high 1 cycle after the 6th field.
- Boundary values:
  - Six fields of 0 produce 0x00, 0x00, 0x00, 0x03.
  - Six fields of 31 produce 0xFF ×4.
  - With TAIL=2'b00, six fields of 0 produce 0x00 ×4.
- Backpressure and input gaps:
  - Fields 1..6 with in_valid gapped every other cycle still produce the 0x08 ... 0x9B bytes.
  - With out_ready low for 5 cycles on byte 2, 0x86 is held stable.
  - While bytes are still pending, in_ready=0 and an offered field 7 is not taken until after the 0x9B handshake.
- clear:
  - clear after 3 fields, then fields 1..6, yields 0x08, 0x86, 0x42, 0x9B; the earlier fields are discarded.
  - clear asserted during byte 2 sets out_valid=0 the next cycle, and no further bytes of that word appear.
- Reset mid-emit:
  - rst_n pulsed low asynchronously between clock edges during byte 1 forces out_valid=0 and in_ready=1 immediately.
  - A subsequent word packs correctly from field 0.
- Random stream: 200 words with random valid/ready. Byte stream must match a reference model of {f0..f5, TAIL} split MSB-first, with out_last every 4th byte.
